axil_lsu_master: RTL and testbench
==================================

# axil_lsu_master

Parametrised AXI4-Lite load/store master placed between the CPU memory stage and any AXI-Lite slave (RAM, MMIO). It accepts one load or store request at a time over a valid/ready handshake and generates byte-lane strobes for sub-word stores. It aligns and sign/zero-extends sub-word loads, detects misaligned accesses, and reports slave errors and bus timeouts. Unlike the previous single-RAM adapter, the slave is external, the address width is configurable, and completion and error status are explicit outputs.

## Interface
- ADDR_WIDTH, 16: AXI address width; the byte address is i_Addr[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 255: maximum cycles spent in a bus state before abort; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).
- i_Clock  in  1  clock.
- i_Reset  in  1  reset, synchronous, active-high.
- i_Req_Valid  in  1  request present.
- o_Req_Ready  out  1  high only in IDLE.
- i_Write_Enable  in  1  store qualifier; a store type with this low is ignored.
- i_Load_Store_Type  in  LS_SEL_WIDTH+1  LS_TYPE_* code from memory.vh.
- i_Addr, i_Data  in  XLEN (32)  byte address; store data in the low bits.
- o_Data  out  32  extended load result; registered.
- o_Done  out  1  one-cycle completion pulse.
- o_Err_Code  out  2  00 OK, 01 bus response error, 10 misaligned, 11 timeout; valid with o_Done.
- o_State  out  3  current FSM state.
- AXI-Lite master ports, 32-bit data:
  - o_axil_araddr[ADDR_WIDTH], o_axil_arvalid, i_axil_arready
  - i_axil_rdata[32], i_axil_rresp[2], i_axil_rvalid, o_axil_rready
  - o_axil_awaddr[ADDR_WIDTH], o_axil_awvalid, i_axil_awready
  - o_axil_wdata[32], o_axil_wstrb[4], o_axil_wvalid, i_axil_wready
  - i_axil_bresp[2], i_axil_bvalid, o_axil_bready

## Operation
- States: IDLE=0, RD_ADDR=1, RD_DATA=2, WR_ADDR_DATA=3, WR_RESP=4, DONE=5.
- IDLE, i_Req_Valid=1:
  - Latch address, data and type.
  - Load types go to RD_ADDR; store types with i_Write_Enable=1 go to WR_ADDR_DATA; anything else is ignored and the FSM stays in IDLE.
  - Misaligned requests go straight to DONE with code 10 and issue no bus traffic. Misaligned means a half with addr[0]=1, or a word with addr[1:0]≠0.
- Bus address is always {addr[ADDR_WIDTH-1:2],2'b00}.
- RD_ADDR: arvalid=1 until arready; then go to RD_DATA.
- RD_DATA: rready=1; on rvalid, go to DONE.
  - Result is rdata >> (8·addr[1:0]), then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW takes rdata unchanged.
  - rresp≠00 gives code 01 and forces o_Data to 0.
- WR_ADDR_DATA: awvalid and wvalid both start at 1. Each drops independently after its own handshake; same-cycle handshakes are allowed. Once both have completed, go to WR_RESP.
- Store strobes and data:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=4'b0011<<addr[1:0], wdata={2{half}}.
  - SW: wstrb=4'b1111, wdata=data.
- WR_RESP: bready=1; on bvalid, go to DONE. bresp≠00 gives code 01.
- DONE: o_Done=1 for one cycle, then go to IDLE. o_Data and o_Err_Code hold until the next completion.
- Timeout: the counter clears on every state change. If it reaches TIMEOUT_CYCLES in RD_*/WR_*, all valids drop and the FSM goes to DONE with code 11. This is a debug abort; the slave must be reset afterwards.
- Outside their states, all AXI address/data/strobe outputs are 0.

## Timing
- Reset: state IDLE, all valid/ready outputs 0, o_Data=0, o_Err_Code=00, o_Done=0, timeout counter 0. A reset mid-transaction aborts it the same way.
- o_Req_Ready=1 in cycle 0 after reset.
- Zero-wait-state read: accept at edge 0, arvalid in cycle 1, rvalid handshake in cycle 2, o_Done in cycle 3 (3-cycle latency).
- Zero-wait write: accept at edge 0, aw and w handshakes in cycle 1, bvalid in cycle 2, o_Done in cycle 3.
- Misaligned request: o_Done in cycle 1.
- All AXI outputs are driven from registered state and latched operands; there is no combinational path from AXI inputs to AXI outputs.

## Test plan
- Reset, zero-wait RAM: SW 0xDEADBEEF to 0x0010, then LW 0x0010 -> wstrb 1111, o_Data=0xDEADBEEF, code 00, o_Done 3 cycles after each accept.
- SB 0x80 to 0x0013, then LB and LBU 0x0013 -> wstrb 1000, wdata 0x80808080; LB=0xFFFFFF80, LBU=0x00000080.
- SH 0x8001 to 0x0012, then LH 0x0012 -> wstrb 1100, o_Data=0xFFFF8001.
- awready delayed 3 cycles with wready immediate -> wvalid drops after cycle 1, awvalid held until its handshake, a single write response, data correct.
- LH to 0x0011 -> o_Done in cycle 1, code 10, arvalid never asserted. Read with rresp=10 -> code 01, o_Data=0.
- TIMEOUT_CYCLES=8, arready stuck low -> arvalid held 8 cycles, then code 11. Assert i_Reset mid-write -> all valids 0 on the next edge, state IDLE.

Source files
------------

// File: rtl/axil_lsu_master.sv
// AXI4-Lite load/store master for the CPU memory stage: one request at a time,
// sub-word strobes and load extension, misalignment, slave error and timeout status.
module axil_lsu_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Req_Valid,
  output logic                  o_Req_Ready,
  input  logic                  i_Write_Enable,
  input  logic [3:0]            i_Load_Store_Type,
  input  logic [31:0]           i_Addr,
  input  logic [31:0]           i_Data,
  output logic [31:0]           o_Data,
  output logic                  o_Done,
  output logic [1:0]            o_Err_Code,
  output logic [2:0]            o_State,
  output logic [ADDR_WIDTH-1:0] o_axil_araddr,
  output logic                  o_axil_arvalid,
  input  logic                  i_axil_arready,
  input  logic [31:0]           i_axil_rdata,
  input  logic [1:0]            i_axil_rresp,
  input  logic                  i_axil_rvalid,
  output logic                  o_axil_rready,
  output logic [ADDR_WIDTH-1:0] o_axil_awaddr,
  output logic                  o_axil_awvalid,
  input  logic                  i_axil_awready,
  output logic [31:0]           o_axil_wdata,
  output logic [3:0]            o_axil_wstrb,
  output logic                  o_axil_wvalid,
  input  logic                  i_axil_wready,
  input  logic [1:0]            i_axil_bresp,
  input  logic                  i_axil_bvalid,
  output logic                  o_axil_bready
);

  localparam int LS_SEL_WIDTH = 3;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LB  = 4'd0;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LH  = 4'd1;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LW  = 4'd2;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LBU = 4'd3;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LHU = 4'd4;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SB  = 4'd5;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SH  = 4'd6;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SW  = 4'd7;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4,
    ST_DONE         = 3'd5
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [1:0]              off_r;
  logic [LS_SEL_WIDTH:0]   type_r;
  logic [31:0]             data_r;
  logic [1:0]              err_r;
  logic                    done_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic                    awvalid_r;
  logic [31:0]             wdata_r;
  logic [3:0]              wstrb_r;
  logic                    wvalid_r;
  logic                    bready_r;

  logic                    is_load_s;
  logic                    is_store_s;
  logic [1:0]              size_s;
  logic                    misaligned_s;
  logic [3:0]              req_wstrb_s;
  logic [31:0]             req_wdata_s;
  logic [ADDR_WIDTH-1:0]   bus_addr_s;
  logic [31:0]             shifted_s;
  logic [31:0]             load_result_s;
  logic                    timeout_s;
  logic                    aw_done_s;
  logic                    w_done_s;
  logic                    unused_s;

  assign bus_addr_s = {i_Addr[ADDR_WIDTH-1:2], 2'b00};
  assign timeout_s  = TO_EN && (cnt_r == TO_LAST);
  assign aw_done_s  = !awvalid_r || i_axil_awready;
  assign w_done_s   = !wvalid_r || i_axil_wready;
  assign unused_s   = ^{i_Addr, i_Data};

  // Request decode: class, access size, misalignment and store lane placement.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    size_s     = SZ_WORD;
    case (i_Load_Store_Type)
      LS_TYPE_LB, LS_TYPE_LBU: begin is_load_s = 1'b1; size_s = SZ_BYTE; end
      LS_TYPE_LH, LS_TYPE_LHU: begin is_load_s = 1'b1; size_s = SZ_HALF; end
      LS_TYPE_LW:              begin is_load_s = 1'b1; size_s = SZ_WORD; end
      LS_TYPE_SB:              begin is_store_s = i_Write_Enable; size_s = SZ_BYTE; end
      LS_TYPE_SH:              begin is_store_s = i_Write_Enable; size_s = SZ_HALF; end
      LS_TYPE_SW:              begin is_store_s = i_Write_Enable; size_s = SZ_WORD; end
      default:                 begin is_load_s = 1'b0; is_store_s = 1'b0; end
    endcase
    misaligned_s = ((size_s == SZ_HALF) && i_Addr[0]) ||
                   ((size_s == SZ_WORD) && (i_Addr[1:0] != 2'b00));
    case (size_s)
      SZ_BYTE: begin
        req_wstrb_s = 4'b0001 << i_Addr[1:0];
        req_wdata_s = {4{i_Data[7:0]}};
      end
      SZ_HALF: begin
        req_wstrb_s = 4'b0011 << i_Addr[1:0];
        req_wdata_s = {2{i_Data[15:0]}};
      end
      default: begin
        req_wstrb_s = 4'b1111;
        req_wdata_s = i_Data;
      end
    endcase
  end

  // Load alignment and extension from the returned word.
  always_comb begin
    shifted_s = i_axil_rdata >> {off_r, 3'b000};
    case (type_r)
      LS_TYPE_LB:  load_result_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LS_TYPE_LBU: load_result_s = {24'h000000, shifted_s[7:0]};
      LS_TYPE_LH:  load_result_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LS_TYPE_LHU: load_result_s = {16'h0000, shifted_s[15:0]};
      default:     load_result_s = shifted_s;
    endcase
  end

  // Main FSM; every bus output is a register updated on state transitions.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      off_r     <= 2'b00;
      type_r    <= '0;
      data_r    <= 32'h0000_0000;
      err_r     <= ERR_OK;
      done_r    <= 1'b0;
      araddr_r  <= '0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awaddr_r  <= '0;
      awvalid_r <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'b0000;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (i_Req_Valid && (is_load_s || is_store_s)) begin
            off_r  <= i_Addr[1:0];
            type_r <= i_Load_Store_Type;
            if (misaligned_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              err_r   <= ERR_MISALIGN;
              data_r  <= 32'h0000_0000;
            end else if (is_load_s) begin
              state_r   <= ST_RD_ADDR;
              arvalid_r <= 1'b1;
              araddr_r  <= bus_addr_s;
            end else begin
              state_r   <= ST_WR_ADDR_DATA;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              awaddr_r  <= bus_addr_s;
              wdata_r   <= req_wdata_s;
              wstrb_r   <= req_wstrb_s;
            end
          end
        end
        ST_RD_ADDR: begin
          if (i_axil_arready) begin
            state_r   <= ST_RD_DATA;
            cnt_r     <= '0;
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
            rready_r  <= 1'b1;
          end else if (timeout_s) begin
            state_r   <= ST_DONE;
            cnt_r     <= '0;
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
            done_r    <= 1'b1;
            err_r     <= ERR_TIMEOUT;
            data_r    <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (i_axil_rvalid) begin
            state_r  <= ST_DONE;
            cnt_r    <= '0;
            rready_r <= 1'b0;
            done_r   <= 1'b1;
            if (i_axil_rresp != 2'b00) begin
              err_r  <= ERR_BUS;
              data_r <= 32'h0000_0000;
            end else begin
              err_r  <= ERR_OK;
              data_r <= load_result_s;
            end
          end else if (timeout_s) begin
            state_r  <= ST_DONE;
            cnt_r    <= '0;
            rready_r <= 1'b0;
            done_r   <= 1'b1;
            err_r    <= ERR_TIMEOUT;
            data_r   <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_WR_ADDR_DATA: begin
          // Address and data channels retire independently, possibly together.
          if (aw_done_s && w_done_s) begin
            state_r   <= ST_WR_RESP;
            cnt_r     <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'b0000;
            bready_r  <= 1'b1;
          end else if (timeout_s) begin
            state_r   <= ST_DONE;
            cnt_r     <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'b0000;
            done_r    <= 1'b1;
            err_r     <= ERR_TIMEOUT;
            data_r    <= 32'h0000_0000;
          end else begin
            cnt_r     <= cnt_r + 1'b1;
            awvalid_r <= awvalid_r && !i_axil_awready;
            wvalid_r  <= wvalid_r && !i_axil_wready;
          end
        end
        ST_WR_RESP: begin
          if (i_axil_bvalid) begin
            state_r  <= ST_DONE;
            cnt_r    <= '0;
            bready_r <= 1'b0;
            done_r   <= 1'b1;
            err_r    <= (i_axil_bresp != 2'b00) ? ERR_BUS : ERR_OK;
          end else if (timeout_s) begin
            state_r  <= ST_DONE;
            cnt_r    <= '0;
            bready_r <= 1'b0;
            done_r   <= 1'b1;
            err_r    <= ERR_TIMEOUT;
            data_r   <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= '0;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Req_Ready    = (state_r == ST_IDLE);
  assign o_State        = state_r;
  assign o_Data         = data_r;
  assign o_Done         = done_r;
  assign o_Err_Code     = err_r;
  assign o_axil_araddr  = araddr_r;
  assign o_axil_arvalid = arvalid_r;
  assign o_axil_rready  = rready_r;
  assign o_axil_awaddr  = awaddr_r;
  assign o_axil_awvalid = awvalid_r;
  assign o_axil_wdata   = wdata_r;
  assign o_axil_wstrb   = wstrb_r;
  assign o_axil_wvalid  = wvalid_r;
  assign o_axil_bready  = bready_r;

endmodule

// File: tb/tb_axil_lsu_master.sv
// Directed bench for axil_lsu_master against a small behavioural AXI-Lite RAM
// with programmable address-write delay, stuck arready and error responses.
module tb_axil_lsu_master;

  localparam logic [3:0] LB  = 4'd0;
  localparam logic [3:0] LH  = 4'd1;
  localparam logic [3:0] LW  = 4'd2;
  localparam logic [3:0] LBU = 4'd3;
  localparam logic [3:0] LHU = 4'd4;
  localparam logic [3:0] SB  = 4'd5;
  localparam logic [3:0] SH  = 4'd6;
  localparam logic [3:0] SW  = 4'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [3:0]  ls_type;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  err;
  logic [2:0]  state;
  logic [15:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int failures = 0;

  // slave configuration, driven by the test sequence
  logic        ar_en;
  int          aw_delay;
  logic [1:0]  rresp_cfg;

  // slave state
  logic [31:0] mem [0:15];
  logic        aw_got, w_got;
  logic [15:0] wa;
  logic [31:0] wd;
  logic [3:0]  ws;
  int          aw_wait;
  int          n_ar_cyc, n_aw_cyc, n_w_cyc, n_b;
  logic [15:0] last_awaddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  always #5 clk = ~clk;

  axil_lsu_master #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Req_Valid(req_valid), .o_Req_Ready(req_ready), .i_Write_Enable(we),
    .i_Load_Store_Type(ls_type), .i_Addr(addr), .i_Data(wr_data),
    .o_Data(rd_data), .o_Done(done), .o_Err_Code(err), .o_State(state),
    .o_axil_araddr(araddr), .o_axil_arvalid(arvalid), .i_axil_arready(arready),
    .i_axil_rdata(rdata), .i_axil_rresp(rresp), .i_axil_rvalid(rvalid), .o_axil_rready(rready),
    .o_axil_awaddr(awaddr), .o_axil_awvalid(awvalid), .i_axil_awready(awready),
    .o_axil_wdata(wdata), .o_axil_wstrb(wstrb), .o_axil_wvalid(wvalid), .i_axil_wready(wready),
    .i_axil_bresp(bresp), .i_axil_bvalid(bvalid), .o_axil_bready(bready)
  );

  logic        aw_hs, w_hs;
  logic [15:0] a_use;
  logic [31:0] d_use;
  logic [3:0]  s_use;
  assign arready = ar_en;
  assign awready = (aw_wait >= aw_delay);
  assign wready  = 1'b1;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign a_use   = aw_got ? wa : awaddr;
  assign d_use   = w_got ? wd : wdata;
  assign s_use   = w_got ? ws : wstrb;

  // Behavioural AXI-Lite RAM plus channel activity counters
  always @(posedge clk) begin
    if (arvalid) n_ar_cyc <= n_ar_cyc + 1;
    if (awvalid) n_aw_cyc <= n_aw_cyc + 1;
    if (wvalid)  n_w_cyc  <= n_w_cyc + 1;
    if (rst) begin
      rvalid <= 1'b0; bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_hs) last_awaddr <= awaddr;
      if (w_hs) begin last_wdata <= wdata; last_wstrb <= wstrb; end
      if (rvalid && rready) rvalid <= 1'b0;
      else if (arvalid && arready && !rvalid) begin
        rvalid <= 1'b1; rdata <= mem[araddr[5:2]]; rresp <= rresp_cfg;
      end
      if (!bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
        for (int i = 0; i < 4; i++)
          if (s_use[i]) mem[a_use[5:2]][8*i +: 8] <= d_use[8*i +: 8];
        bvalid <= 1'b1; bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; wa <= awaddr; end
        if (w_hs) begin w_got <= 1'b1; wd <= wdata; ws <= wstrb; end
      end
      if (bvalid && bready) begin bvalid <= 1'b0; n_b <= n_b + 1; end
    end
  end

  // Issue one request and return the cycle (after the accept edge) in which o_Done is seen; 0 if never.
  task automatic do_req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic w, output int lat);
    @(negedge clk);
    req_valid = 1'b1; ls_type = t; addr = a; wr_data = d; we = w;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({done, err, rd_data} !== 35'd0) begin failures++; $display("FAIL reset_outputs done=%b err=%b data=%h exp 0", done, err, rd_data); end
    checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b00000) begin failures++; $display("FAIL reset_axi got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); end
  endtask

  task automatic test_word();
    int lat;
    do_req(SW, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", lat); end
    checks++; if (last_wstrb !== 4'b1111) begin failures++; $display("FAIL sw_wstrb got=%b exp=1111", last_wstrb); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL sw_err got=%b exp=00", err); end
    do_req(LW, 32'h0000_0010, 32'h0, 1'b0, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", rd_data); end
  endtask

  task automatic test_byte();
    int lat;
    do_req(SB, 32'h0000_0013, 32'h1234_5680, 1'b1, lat);
    checks++; if (last_wstrb !== 4'b1000) begin failures++; $display("FAIL sb_wstrb got=%b exp=1000", last_wstrb); end
    checks++; if (last_wdata !== 32'h8080_8080) begin failures++; $display("FAIL sb_wdata got=%h exp=80808080", last_wdata); end
    checks++; if (last_awaddr !== 16'h0010) begin failures++; $display("FAIL sb_awaddr got=%h exp=0010", last_awaddr); end
    do_req(LB, 32'h0000_0013, 32'h0, 1'b0, lat);
    checks++; if (rd_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", rd_data); end
    do_req(LBU, 32'h0000_0013, 32'h0, 1'b0, lat);
    checks++; if (rd_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", rd_data); end
  endtask

  task automatic test_half();
    int lat;
    do_req(SH, 32'h0000_0012, 32'h0000_8001, 1'b1, lat);
    checks++; if (last_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", last_wstrb); end
    checks++; if (last_wdata !== 32'h8001_8001) begin failures++; $display("FAIL sh_wdata got=%h exp=80018001", last_wdata); end
    do_req(LH, 32'h0000_0012, 32'h0, 1'b0, lat);
    checks++; if (rd_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", rd_data); end
    do_req(LHU, 32'h0000_0012, 32'h0, 1'b0, lat);
    checks++; if (rd_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", rd_data); end
    do_req(LW, 32'h0000_0010, 32'h0, 1'b0, lat);
    checks++; if (rd_data !== 32'h8001_BEEF) begin failures++; $display("FAIL merged_word got=%h exp=8001beef", rd_data); end
  endtask

  task automatic test_ignored();
    int aw0;
    aw0 = n_aw_cyc;
    @(negedge clk);
    req_valid = 1'b1; ls_type = SB; addr = 32'h0000_0014; wr_data = 32'h0000_00AA; we = 1'b0;
    @(negedge clk);
    ls_type = 4'd9; we = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL ignored_state got=%0d exp=0", state); end
    repeat (2) @(negedge clk);
    checks++; if (n_aw_cyc - aw0 !== 0) begin failures++; $display("FAIL ignored_bus got=%0d exp=0", n_aw_cyc - aw0); end
  endtask

  task automatic test_delayed_aw();
    int lat, aw0, w0, b0;
    aw0 = n_aw_cyc; w0 = n_w_cyc; b0 = n_b;
    aw_delay = 3;
    do_req(SW, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL dly_latency got=%0d exp=6", lat); end
    checks++; if (n_aw_cyc - aw0 !== 4) begin failures++; $display("FAIL dly_awvalid_cycles got=%0d exp=4", n_aw_cyc - aw0); end
    checks++; if (n_w_cyc - w0 !== 1) begin failures++; $display("FAIL dly_wvalid_cycles got=%0d exp=1", n_w_cyc - w0); end
    checks++; if (n_b - b0 !== 1) begin failures++; $display("FAIL dly_bresp_count got=%0d exp=1", n_b - b0); end
    aw_delay = 0;
    do_req(LW, 32'h0000_0020, 32'h0, 1'b0, lat);
    checks++; if (rd_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL dly_readback got=%h exp=cafef00d", rd_data); end
  endtask

  task automatic test_errors();
    int lat, ar0;
    ar0 = n_ar_cyc;
    do_req(LH, 32'h0000_0011, 32'h0, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL mis_latency got=%0d exp=1", lat); end
    checks++; if (err !== 2'b10) begin failures++; $display("FAIL mis_err got=%b exp=10", err); end
    checks++; if (n_ar_cyc - ar0 !== 0) begin failures++; $display("FAIL mis_arvalid got=%0d exp=0", n_ar_cyc - ar0); end
    rresp_cfg = 2'b10;
    do_req(LW, 32'h0000_0010, 32'h0, 1'b0, lat);
    rresp_cfg = 2'b00;
    checks++; if (err !== 2'b01) begin failures++; $display("FAIL rresp_err got=%b exp=01", err); end
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL rresp_data got=%h exp=00000000", rd_data); end
  endtask

  task automatic test_timeout();
    int lat, ar0;
    ar0 = n_ar_cyc;
    ar_en = 1'b0;
    do_req(LW, 32'h0000_0020, 32'h0, 1'b0, lat);
    ar_en = 1'b1;
    checks++; if (n_ar_cyc - ar0 !== 8) begin failures++; $display("FAIL to_arvalid_cycles got=%0d exp=8", n_ar_cyc - ar0); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL to_latency got=%0d exp=9", lat); end
    checks++; if (err !== 2'b11) begin failures++; $display("FAIL to_err got=%b exp=11", err); end
    @(negedge clk);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL to_idle got=%0d exp=0", state); end
  endtask

  task automatic test_reset_mid_write();
    aw_delay = 6;
    @(negedge clk);
    req_valid = 1'b1; ls_type = SW; addr = 32'h0000_0024; wr_data = 32'h1111_2222; we = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (awvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre_awvalid got=%b exp=1", awvalid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b00000) begin failures++; $display("FAIL midrst_valids got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", state); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL midrst_err got=%b exp=00", err); end
    @(negedge clk) rst = 1'b0;
    aw_delay = 0;
  endtask

  initial begin
    req_valid = 1'b0; we = 1'b0; ls_type = 4'd0; addr = 32'h0; wr_data = 32'h0;
    ar_en = 1'b1; aw_delay = 0; rresp_cfg = 2'b00;
    n_ar_cyc = 0; n_aw_cyc = 0; n_w_cyc = 0; n_b = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_ignored();
    test_delayed_aw();
    test_errors();
    test_timeout();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
